ext_bus_arbiter: RTL and testbench
==================================

EXT_BUS_ARBITER -- requirements
Module: ext_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of requesting masters (1..8).
REQ-002 SHALL have parameter ADDR_W, default 16, external address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; byte-enable width WE_W = DATA_W/8.
REQ-004 SHALL have parameter TIMEOUT, default 255, the maximum cycles waited for ext ack; 0 disables the timeout.
REQ-005 SHALL have port i_clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_m_stb  input  N_MASTERS  per-master request strobe.
REQ-008 SHALL have port i_m_addr  input  N_MASTERS*ADDR_W  packed addresses, master k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port i_m_we  input  N_MASTERS*WE_W  packed byte write enables; all-zero means read.
REQ-010 SHALL have port i_m_dat_w  input  N_MASTERS*DATA_W  packed write data.
REQ-011 SHALL have port o_m_ack  output  N_MASTERS  per-master one-cycle completion pulse.
REQ-012 SHALL have port o_m_err  output  1  qualifies o_m_ack; 1 = transaction timed out.
REQ-013 SHALL have port o_m_dat_r  output  DATA_W  read data, shared, valid with o_m_ack.
REQ-014 SHALL have ports o_ext_addr (ADDR_W), o_ext_stb (1), o_ext_we (WE_W), o_ext_dat_w (DATA_W) as outputs, and i_ext_ack (1), i_ext_dat_r (DATA_W) as inputs: the external bus.
REQ-015 SHALL have port o_timeout_cnt  output  8  saturating count of timed-out transactions.

Function
REQ-016 SHALL implement states IDLE, BUSY, DONE; all outputs registered.
REQ-017 Masters SHALL hold stb, addr, we, dat_w stable from assertion until they see their o_m_ack, then deassert stb in the following cycle at the latest.
REQ-018 In IDLE with any i_m_stb set, the arbiter SHALL select a grant via round-robin starting at index (last_grant+1) mod N_MASTERS, latch its addr/we/dat_w onto o_ext_*, set o_ext_stb=1 and enter BUSY on the next edge (1-cycle request-to-strobe latency).
REQ-019 In BUSY, o_ext_stb and o_ext_* SHALL stay constant; a cycle counter SHALL increment each BUSY cycle starting at 1.
REQ-020 In BUSY with i_ext_ack=1: next edge o_ext_stb=0, o_m_ack[grant]=1 for exactly one cycle, o_m_dat_r=i_ext_dat_r (captured for both reads and writes), o_m_err=0, enter DONE, and last_grant=grant.
REQ-021 In BUSY with TIMEOUT!=0, counter==TIMEOUT and i_ext_ack=0: next edge o_ext_stb=0, o_m_ack[grant]=1, o_m_err=1, o_m_dat_r=0, o_timeout_cnt incremented (saturating at 255), enter DONE, and last_grant=grant.
REQ-022 When ack and timeout coincide in the same cycle, ack SHALL win (normal completion, no error, counter not incremented).
REQ-023 DONE SHALL last exactly one cycle, ignore all requests (turnaround so the acked master's stale stb is not regranted), clear o_m_ack/o_m_err, then return to IDLE.
REQ-024 i_ext_ack outside BUSY SHALL be ignored.
REQ-025 A master's stb that deasserts before being granted SHALL lose its request with no side effect.
REQ-026 With N_MASTERS=1 the block SHALL behave as a registered pass-through with timeout.

Reset
REQ-027 On i_rst=1 at a clock edge: state=IDLE, last_grant=N_MASTERS-1 (so master 0 has first priority), o_ext_stb=0, o_ext_addr/we/dat_w=0, o_m_ack=0, o_m_err=0, o_m_dat_r=0, o_timeout_cnt=0, cycle counter=0.
REQ-028 Reset asserted mid-transaction SHALL abort it: no o_m_ack is issued and o_ext_stb is 0 in the cycle after the reset edge.

Verification
REQ-029 Single read: master 0 stb, addr 0x0010, we 0; ext ack 2 cycles after o_ext_stb with dat 0xCAFEF00D -> o_m_ack[0] one cycle, o_m_dat_r=0xCAFEF00D, o_m_err=0.
REQ-030 Contention: masters 0 and 1 request continuously, each repeating after ack -> grants alternate 0,1,0,1; each o_ext_stb is preceded by at least one idle-stb cycle (DONE).
REQ-031 Timeout: TIMEOUT=4, ext never acks -> o_ext_stb high for 4 cycles, then o_m_ack with o_m_err=1, o_m_dat_r=0, o_timeout_cnt=1.
REQ-032 Ack on the timeout cycle: ack at counter==TIMEOUT -> o_m_err=0, data captured, o_timeout_cnt unchanged.
REQ-033 Write byte enables: master 1 we=0b0011, dat 0x12345678 -> o_ext_we=0b0011, o_ext_dat_w=0x12345678 held stable until ack.
REQ-034 Reset mid-BUSY -> no o_m_ack, o_ext_stb=0 next cycle, master 0 granted first afterwards.

Source files
------------

// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter funnelling N request masters onto one external bus,
// with a per-transaction ack timeout and a saturating timed-out counter.
module ext_bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [N_MASTERS-1:0]            i_m_stb,
    input  logic [N_MASTERS*ADDR_W-1:0]     i_m_addr,
    input  logic [N_MASTERS*(DATA_W/8)-1:0] i_m_we,
    input  logic [N_MASTERS*DATA_W-1:0]     i_m_dat_w,
    output logic [N_MASTERS-1:0]            o_m_ack,
    output logic                            o_m_err,
    output logic [DATA_W-1:0]               o_m_dat_r,
    output logic [ADDR_W-1:0]               o_ext_addr,
    output logic                            o_ext_stb,
    output logic [(DATA_W/8)-1:0]           o_ext_we,
    output logic [DATA_W-1:0]               o_ext_dat_w,
    input  logic                            i_ext_ack,
    input  logic [DATA_W-1:0]               i_ext_dat_r,
    output logic [7:0]                      o_timeout_cnt
);

    localparam int WE_W  = DATA_W / 8;
    localparam int GW    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
    logic                   ext_stb_q, ext_stb_d;
    logic [ADDR_W-1:0]      ext_addr_q, ext_addr_d;
    logic [WE_W-1:0]        ext_we_q, ext_we_d;
    logic [DATA_W-1:0]      ext_dat_w_q, ext_dat_w_d;
    logic [N_MASTERS-1:0]   m_ack_q, m_ack_d;
    logic                   m_err_q, m_err_d;
    logic [DATA_W-1:0]      m_dat_r_q, m_dat_r_d;
    logic [7:0]             timeout_cnt_q, timeout_cnt_d;

    logic [GW-1:0]          rr_idx;
    logic [GW-1:0]          rr_pick;
    logic                   rr_found;
    logic [ADDR_W-1:0]      sel_addr;
    logic [WE_W-1:0]        sel_we;
    logic [DATA_W-1:0]      sel_dat;
    logic [N_MASTERS-1:0]   grant_oh;
    logic                   timed_out;

    // First requester found scanning upward from the master after the last grant.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_grant_q;
        rr_idx   = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            rr_idx = GW'((int'(last_grant_q) + i) % N_MASTERS);
            if (!rr_found && i_m_stb[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_we   = '0;
        sel_dat  = '0;
        grant_oh = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (rr_pick == GW'(k)) begin
                sel_addr = i_m_addr[k*ADDR_W +: ADDR_W];
                sel_we   = i_m_we[k*WE_W +: WE_W];
                sel_dat  = i_m_dat_w[k*DATA_W +: DATA_W];
            end
            grant_oh[k] = (grant_q == GW'(k));
        end
    end

    assign timed_out = (TIMEOUT != 0) && (cycle_cnt_q == CNT_W'(TIMEOUT));

    // Ack is tested before the timeout so a late ack on the last allowed cycle still completes cleanly.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        cycle_cnt_d   = cycle_cnt_q;
        ext_stb_d     = ext_stb_q;
        ext_addr_d    = ext_addr_q;
        ext_we_d      = ext_we_q;
        ext_dat_w_d   = ext_dat_w_q;
        m_ack_d       = '0;
        m_err_d       = 1'b0;
        m_dat_r_d     = m_dat_r_q;
        timeout_cnt_d = timeout_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d     = rr_pick;
                    ext_stb_d   = 1'b1;
                    ext_addr_d  = sel_addr;
                    ext_we_d    = sel_we;
                    ext_dat_w_d = sel_dat;
                    cycle_cnt_d = CNT_W'(1);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (i_ext_ack) begin
                    ext_stb_d    = 1'b0;
                    m_ack_d      = grant_oh;
                    m_dat_r_d    = i_ext_dat_r;
                    last_grant_d = grant_q;
                    cycle_cnt_d  = '0;
                    state_d      = DONE;
                end else if (timed_out) begin
                    ext_stb_d    = 1'b0;
                    m_ack_d      = grant_oh;
                    m_err_d      = 1'b1;
                    m_dat_r_d    = '0;
                    last_grant_d = grant_q;
                    cycle_cnt_d  = '0;
                    state_d      = DONE;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end else begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            last_grant_q  <= GW'(N_MASTERS - 1);
            grant_q       <= '0;
            cycle_cnt_q   <= '0;
            ext_stb_q     <= 1'b0;
            ext_addr_q    <= '0;
            ext_we_q      <= '0;
            ext_dat_w_q   <= '0;
            m_ack_q       <= '0;
            m_err_q       <= 1'b0;
            m_dat_r_q     <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            cycle_cnt_q   <= cycle_cnt_d;
            ext_stb_q     <= ext_stb_d;
            ext_addr_q    <= ext_addr_d;
            ext_we_q      <= ext_we_d;
            ext_dat_w_q   <= ext_dat_w_d;
            m_ack_q       <= m_ack_d;
            m_err_q       <= m_err_d;
            m_dat_r_q     <= m_dat_r_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign o_m_ack       = m_ack_q;
    assign o_m_err       = m_err_q;
    assign o_m_dat_r     = m_dat_r_q;
    assign o_ext_stb     = ext_stb_q;
    assign o_ext_addr    = ext_addr_q;
    assign o_ext_we      = ext_we_q;
    assign o_ext_dat_w   = ext_dat_w_q;
    assign o_timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Bench for ext_bus_arbiter: directed scenarios plus randomized masters and
// external slave, checked every cycle against a transaction-level reference.
module tb_ext_bus_arbiter;

    localparam int NM = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int WW = DW / 8;
    localparam int TO = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst = 1'b1;
    logic [NM-1:0]       m_stb = '0;
    logic [NM*AW-1:0]    m_addr = '0;
    logic [NM*WW-1:0]    m_we = '0;
    logic [NM*DW-1:0]    m_dat_w = '0;
    logic                ext_ack = 1'b0;
    logic [DW-1:0]       ext_dat_r = '0;
    logic [NM-1:0]       m_ack;
    logic                m_err;
    logic [DW-1:0]       m_dat_r;
    logic [AW-1:0]       ext_addr;
    logic                ext_stb;
    logic [WW-1:0]       ext_we;
    logic [DW-1:0]       ext_dat_w;
    logic [7:0]          tocnt;

    ext_bus_arbiter #(
        .N_MASTERS(NM),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TIMEOUT  (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_m_stb      (m_stb),
        .i_m_addr     (m_addr),
        .i_m_we       (m_we),
        .i_m_dat_w    (m_dat_w),
        .o_m_ack      (m_ack),
        .o_m_err      (m_err),
        .o_m_dat_r    (m_dat_r),
        .o_ext_addr   (ext_addr),
        .o_ext_stb    (ext_stb),
        .o_ext_we     (ext_we),
        .o_ext_dat_w  (ext_dat_w),
        .i_ext_ack    (ext_ack),
        .i_ext_dat_r  (ext_dat_r),
        .o_timeout_cnt(tocnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Master-side request bookkeeping; stale keeps stb up for one cycle after an ack.
    bit            pend[NM];
    bit            stale[NM];
    bit            a_stb[NM];
    logic [AW-1:0] r_addr[NM];
    logic [WW-1:0] r_we[NM];
    logic [DW-1:0] r_dat[NM];

    // Reference: transaction in flight, cycles it has been on the bus, turnaround pending.
    bit            busy = 1'b0;
    bit            turn = 1'b0;
    int            grant = 0;
    int            last = NM - 1;
    int            waited = 0;
    logic          e_stb = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [WW-1:0] e_we = '0;
    logic [DW-1:0] e_dw = '0;
    logic [NM-1:0] e_ack = '0;
    logic          e_err = 1'b0;
    logic [DW-1:0] e_dr = '0;
    logic [7:0]    e_tocnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic driveBus();
        for (int k = 0; k < NM; k++) begin
            a_stb[k] = pend[k] || stale[k];
            m_stb[IW'(k)] = a_stb[k];
            m_addr[k*AW +: AW] = r_addr[k];
            m_we[k*WW +: WW] = r_we[k];
            m_dat_w[k*DW +: DW] = r_dat[k];
        end
    endtask

    task automatic modelStep();
        bit found;
        int k;
        if (rst) begin
            e_stb = 1'b0; e_addr = '0; e_we = '0; e_dw = '0;
            e_ack = '0; e_err = 1'b0; e_dr = '0; e_tocnt = '0;
            busy = 1'b0; turn = 1'b0; last = NM - 1; waited = 0;
        end else begin
            e_ack = '0;
            e_err = 1'b0;
            if (turn) begin
                turn = 1'b0;
            end else if (busy) begin
                if (ext_ack || (TO != 0 && waited == TO)) begin
                    e_stb = 1'b0;
                    e_ack[IW'(grant)] = 1'b1;
                    last = grant;
                    busy = 1'b0;
                    turn = 1'b1;
                    if (ext_ack) begin
                        e_dr = ext_dat_r;
                    end else begin
                        e_err = 1'b1;
                        e_dr = '0;
                        if (e_tocnt != 8'd255) e_tocnt = e_tocnt + 8'd1;
                    end
                end else begin
                    waited++;
                end
            end else begin
                found = 1'b0;
                for (int i = 1; i <= NM; i++) begin
                    k = (last + i) % NM;
                    if (!found && a_stb[k]) begin
                        found = 1'b1;
                        grant = k;
                    end
                end
                if (found) begin
                    busy = 1'b1;
                    waited = 1;
                    e_stb = 1'b1;
                    e_addr = r_addr[grant];
                    e_we = r_we[grant];
                    e_dw = r_dat[grant];
                end
            end
        end
    endtask

    task automatic checkOutput();
        check("ext_stb", 64'(ext_stb), 64'(e_stb));
        check("m_ack", 64'(m_ack), 64'(e_ack));
        check("m_err", 64'(m_err), 64'(e_err));
        check("timeout_cnt", 64'(tocnt), 64'(e_tocnt));
        if (e_stb) begin
            check("ext_addr", 64'(ext_addr), 64'(e_addr));
            check("ext_we", 64'(ext_we), 64'(e_we));
            check("ext_dat_w", 64'(ext_dat_w), 64'(e_dw));
        end
        if (e_ack != '0) check("m_dat_r", 64'(m_dat_r), 64'(e_dr));
    endtask

    task automatic cycle();
        driveBus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input int req_pct, input int ack_pct, input int wd_pct,
                                 input logic [NM-1:0] mask, input bit hold_stale, input int rst_odds);
        for (int k = 0; k < NM; k++) begin
            if (stale[k]) begin
                stale[k] = 1'b0;
            end else if (pend[k] && m_ack[IW'(k)]) begin
                pend[k] = 1'b0;
                stale[k] = hold_stale || ($urandom_range(1) == 1);
            end else if (!pend[k]) begin
                if (mask[IW'(k)] && $urandom_range(99) < req_pct) begin
                    pend[k] = 1'b1;
                    r_addr[k] = AW'($urandom);
                    r_we[k] = ($urandom_range(1) == 1) ? '0 : WW'($urandom);
                    r_dat[k] = $urandom;
                end
            end else if (!(busy && grant == k) && $urandom_range(99) < wd_pct) begin
                pend[k] = 1'b0;
            end
        end
        ext_ack = ($urandom_range(99) < ack_pct);
        ext_dat_r = $urandom;
        rst = (rst_odds > 0) && ($urandom_range(rst_odds - 1) == 0);
    endtask

    function automatic bit allQuiet();
        bit q = !busy && !turn;
        for (int k = 0; k < NM; k++) if (pend[k] || stale[k]) q = 1'b0;
        return q;
    endfunction

    task automatic drain();
        bit quiet = 1'b0;
        for (int c = 0; c < 200 && !quiet; c++) begin
            applyStimulus(0, 100, 0, '0, 1'b0, 0);
            cycle();
            quiet = allQuiet();
        end
        check("drain_quiet", 64'(quiet), 64'(1));
        ext_ack = 1'b0;
    endtask

    task automatic request(input int k, input logic [AW-1:0] a, input logic [WW-1:0] w, input logic [DW-1:0] d);
        pend[k] = 1'b1;
        r_addr[k] = a;
        r_we[k] = w;
        r_dat[k] = d;
    endtask

    initial begin
        int hi;
        int n_to;
        int got[$];
        bit prev_ack;
        for (int k = 0; k < NM; k++) begin
            pend[k] = 1'b0; stale[k] = 1'b0; a_stb[k] = 1'b0;
            r_addr[k] = '0; r_we[k] = '0; r_dat[k] = '0;
        end

        rst = 1'b1;
        cycle();
        check("rst_ext_stb", 64'(ext_stb), 64'(0));
        check("rst_ext_addr", 64'(ext_addr), 64'(0));
        check("rst_ext_we", 64'(ext_we), 64'(0));
        check("rst_ext_dat_w", 64'(ext_dat_w), 64'(0));
        check("rst_m_ack", 64'(m_ack), 64'(0));
        check("rst_m_dat_r", 64'(m_dat_r), 64'(0));
        check("rst_tocnt", 64'(tocnt), 64'(0));
        rst = 1'b0;

        // Single read, acked two cycles after the strobe appears.
        request(0, 16'h0010, 4'h0, 32'h0);
        cycle();
        check("rd_stb", 64'(ext_stb), 64'(1));
        check("rd_addr", 64'(ext_addr), 64'h0010);
        cycle();
        ext_ack = 1'b1;
        ext_dat_r = 32'hCAFEF00D;
        cycle();
        check("rd_ack", 64'(m_ack), 64'(3'b001));
        check("rd_data", 64'(m_dat_r), 64'hCAFEF00D);
        check("rd_err", 64'(m_err), 64'(0));
        pend[0] = 1'b0;
        ext_ack = 1'b0;
        cycle();
        check("rd_ack_one_cycle", 64'(m_ack), 64'(0));
        cycle();

        // Timeout: slave never answers.
        request(2, 16'h0222, 4'h0, 32'h0);
        hi = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (ext_stb) hi++;
            if (m_ack != '0) break;
        end
        check("to_stb_cycles", 64'(hi), 64'(4));
        check("to_ack", 64'(m_ack), 64'(3'b100));
        check("to_err", 64'(m_err), 64'(1));
        check("to_data", 64'(m_dat_r), 64'(0));
        check("to_cnt", 64'(tocnt), 64'(1));
        pend[2] = 1'b0;
        cycle();

        // Ack lands on the very cycle the timeout would fire.
        request(0, 16'h0300, 4'h0, 32'h0);
        cycle();
        repeat (3) cycle();
        ext_ack = 1'b1;
        ext_dat_r = 32'h0BADBEEF;
        cycle();
        check("late_ack", 64'(m_ack), 64'(3'b001));
        check("late_err", 64'(m_err), 64'(0));
        check("late_data", 64'(m_dat_r), 64'h0BADBEEF);
        check("late_cnt", 64'(tocnt), 64'(1));
        pend[0] = 1'b0;
        ext_ack = 1'b0;
        cycle();

        // Byte-enabled write held stable on the bus until acked.
        request(1, 16'h0200, 4'b0011, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("wr_stb", 64'(ext_stb), 64'(1));
            check("wr_we", 64'(ext_we), 64'(4'b0011));
            check("wr_dat", 64'(ext_dat_w), 64'h12345678);
        end
        ext_ack = 1'b1;
        cycle();
        check("wr_ack", 64'(m_ack), 64'(3'b010));
        pend[1] = 1'b0;
        ext_ack = 1'b0;
        cycle();

        // Masters 0 and 1 contend continuously; the last grant was master 1.
        prev_ack = 1'b0;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(100, 60, 0, 3'b011, 1'b1, 0);
            cycle();
            if (prev_ack) check("turnaround_stb", 64'(ext_stb), 64'(0));
            prev_ack = (m_ack != '0);
            for (int k = 0; k < NM; k++) if (m_ack[IW'(k)]) got.push_back(k);
        end
        check("rr_count_ok", 64'(got.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++) check("rr_order", 64'((got.size() > i) ? got[i] : 99), 64'(i % 2));
        drain();

        // Reset in the middle of a transaction aborts it.
        request(1, 16'h1111, 4'h0, 32'h0);
        cycle();
        check("rb_stb", 64'(ext_stb), 64'(1));
        cycle();
        rst = 1'b1;
        ext_ack = 1'b1;
        cycle();
        check("rb_stb_off", 64'(ext_stb), 64'(0));
        check("rb_no_ack", 64'(m_ack), 64'(0));
        rst = 1'b0;
        ext_ack = 1'b0;
        request(0, 16'hA000, 4'h0, 32'h0);
        request(2, 16'hC000, 4'h0, 32'h0);
        cycle();
        check("rb_regrant_stb", 64'(ext_stb), 64'(1));
        check("rb_regrant_addr", 64'(ext_addr), 64'hA000);
        ext_ack = 1'b1;
        ext_dat_r = 32'h5A5A5A5A;
        cycle();
        check("rb_ack0", 64'(m_ack), 64'(3'b001));
        pend[0] = 1'b0;
        drain();

        $display("[TB] random phase");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(30, 35, 5, '1, 1'b0, 300);
            cycle();
        end
        drain();

        // Drive the timeout counter into saturation.
        n_to = 0;
        for (int c = 0; c < 2500 && n_to < 260; c++) begin
            applyStimulus(100, 0, 0, '1, 1'b0, 0);
            cycle();
            if (m_err) n_to++;
        end
        check("sat_tocnt", 64'(tocnt), 64'(8'hFF));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
